// File: rtl/nios2_ocimem_pkg.sv
// Shared types and constants for the OCI debug-RAM arbiter.
package nios2_ocimem_pkg;

    localparam int OCI_ADDR_W = 8;
    localparam int RAM_RD_LAT = 1;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_JTAG = 2'd2
    } gnt_e;

endpackage

// File: rtl/nios2_ocimem_jtag_cmd.sv
// JTAG strobe decode: one-deep pending-op register, auto-incrementing
// address counter and sticky overrun flag.
module nios2_ocimem_jtag_cmd
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       i_jdo,
    input  logic              i_act_a,
    input  logic              i_noact_a,
    input  logic              i_act_b,
    input  logic              i_grant,
    output op_e               o_pending,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_wdata,
    output logic              o_overrun
);

    op_e               r_pending, w_next_pending;
    logic [ADDR_W-1:0] r_addr, w_next_addr;
    logic [31:0]       r_wdata;
    logic              r_overrun;
    logic              w_free, w_drop, w_load_wdata;
    logic              w_unused_jdo;

    assign w_unused_jdo = ^{i_jdo[36:35], i_jdo[1:0]};

    // The slot frees up in its own grant cycle, so a strobe landing then is accepted.
    assign w_free = (r_pending == OP_NONE) | i_grant;

    always_comb begin
        w_next_pending = i_grant ? OP_NONE : r_pending;
        w_next_addr    = i_grant ? r_addr + 1'b1 : r_addr;
        w_drop         = 1'b0;
        w_load_wdata   = 1'b0;
        if (i_act_a) begin
            if (w_free) begin
                w_next_addr = i_jdo[ADDR_W+1:2];
                if (i_jdo[37]) w_next_pending = OP_RD;
            end else begin
                w_drop = 1'b1;
            end
            if (i_act_b | i_noact_a) w_drop = 1'b1;
        end else if (i_act_b) begin
            if (w_free) begin
                w_next_pending = OP_WR;
                w_load_wdata   = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
            if (i_noact_a) w_drop = 1'b1;
        end else if (i_noact_a) begin
            if (w_free) w_next_pending = OP_RD;
            else        w_drop         = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= OP_NONE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= w_next_pending;
            r_addr    <= w_next_addr;
            if (w_load_wdata) r_wdata <= i_jdo[34:3];
            if (w_drop) r_overrun <= 1'b1;
        end
    end

    assign o_pending = r_pending;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Round-robin arbiter sharing the OCI debug RAM between CPU and JTAG.
// Optional OCIMEM_ROM_PROTECT_EN blocks CPU writes to the lower (ROM) half.
module nios2_ocimem_arbiter
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              mon_ready,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    op_e               w_pending;
    logic [ADDR_W-1:0] w_jtag_addr;
    logic [31:0]       w_jtag_wdata;
    logic              w_cpu_req, w_jtag_req, w_cpu_wren;
    gnt_e              w_gnt, r_last_gnt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
    logic              w_ram_wren;
    logic [3:0]        w_ram_byteen;
    logic [31:0]       w_ram_wdata;
    logic              r_cpu_rvalid, r_jtag_ack, r_jtag_rd;
    logic [31:0]       r_mon;

    nios2_ocimem_jtag_cmd #(.ADDR_W(ADDR_W)) u_cmd (
        .clk       (clk),
        .reset     (reset),
        .i_jdo     (jdo),
        .i_act_a   (take_action_ocimem_a),
        .i_noact_a (take_no_action_ocimem_a),
        .i_act_b   (take_action_ocimem_b),
        .i_grant   (w_gnt == GNT_JTAG),
        .o_pending (w_pending),
        .o_addr    (w_jtag_addr),
        .o_wdata   (w_jtag_wdata),
        .o_overrun (jtag_overrun)
    );

    assign w_cpu_req  = cpu_read | cpu_write;
    assign w_jtag_req = (w_pending != OP_NONE);

`ifdef OCIMEM_ROM_PROTECT_EN
    assign w_cpu_wren = cpu_write & cpu_address[ADDR_W-1];
`else
    assign w_cpu_wren = cpu_write;
`endif

    // Under contention the requester not granted last wins; idle history favours the CPU.
    always_comb begin
        w_gnt = GNT_NONE;
        if (w_cpu_req && w_jtag_req)  w_gnt = (r_last_gnt == GNT_CPU) ? GNT_JTAG : GNT_CPU;
        else if (w_cpu_req)           w_gnt = GNT_CPU;
        else if (w_jtag_req)          w_gnt = GNT_JTAG;
    end

    always_comb begin
        w_ram_addr   = r_ram_addr;
        w_ram_wren   = 1'b0;
        w_ram_byteen = 4'h0;
        w_ram_wdata  = 32'h0;
        case (w_gnt)
            GNT_CPU: begin
                w_ram_addr   = cpu_address;
                w_ram_wren   = w_cpu_wren;
                w_ram_byteen = cpu_byteenable;
                w_ram_wdata  = cpu_writedata;
            end
            GNT_JTAG: begin
                w_ram_addr   = w_jtag_addr;
                w_ram_wren   = (w_pending == OP_WR);
                w_ram_byteen = 4'hF;
                w_ram_wdata  = w_jtag_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt   <= GNT_NONE;
            r_ram_addr   <= '0;
            r_cpu_rvalid <= 1'b0;
            r_jtag_ack   <= 1'b0;
            r_jtag_rd    <= 1'b0;
            r_mon        <= '0;
        end else begin
            if (w_cpu_req && w_jtag_req) r_last_gnt <= w_gnt;
            if (w_gnt != GNT_NONE) r_ram_addr <= w_ram_addr;
            r_cpu_rvalid <= (w_gnt == GNT_CPU) & cpu_read & ~cpu_write;
            r_jtag_ack   <= (w_gnt == GNT_JTAG);
            r_jtag_rd    <= (w_gnt == GNT_JTAG) & (w_pending == OP_RD);
            if (r_jtag_rd) r_mon <= ram_rdata;
        end
    end

    assign cpu_waitrequest   = w_cpu_req & (w_gnt != GNT_CPU);
    assign cpu_readdatavalid = r_cpu_rvalid;
    assign cpu_readdata      = r_cpu_rvalid ? ram_rdata : 32'h0;
    // The RAM returns data in the cycle after the grant, so MonDReg bypasses it then.
    assign MonDReg           = r_jtag_rd ? ram_rdata : r_mon;
    assign mon_ready         = r_jtag_ack;
    assign jtag_busy         = w_jtag_req | r_jtag_rd;
    assign ram_addr          = w_ram_addr;
    assign ram_wren          = w_ram_wren;
    assign ram_byteen        = w_ram_byteen;
    assign ram_wdata         = w_ram_wdata;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter with a behavioural 256x32 RAM.
module tb_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cpu_address = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic        cpu_waitrequest, cpu_readdatavalid;
  logic [31:0] cpu_readdata;
  logic [37:0] jdo = '0;
  logic        act_a = 1'b0, noact_a = 1'b0, act_b = 1'b0;
  logic [31:0] MonDReg;
  logic        mon_ready, jtag_busy, jtag_overrun;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] mem [0:255];
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid), .jdo(jdo),
    .take_action_ocimem_a(act_a), .take_no_action_ocimem_a(noact_a),
    .take_action_ocimem_b(act_b), .MonDReg(MonDReg), .mon_ready(mon_ready),
    .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun), .ram_addr(ram_addr),
    .ram_wren(ram_wren), .ram_byteen(ram_byteen), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [37:0] jdo_addr(input logic rd, input logic [7:0] a);
    return {rd, 27'b0, a, 2'b0};
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return {3'b0, d, 3'b0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    cyc(); cyc();
    chk("rst_wait", {31'b0, cpu_waitrequest}, 0);
    chk("rst_rvalid", {31'b0, cpu_readdatavalid}, 0);
    chk("rst_monready", {31'b0, mon_ready}, 0);
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_busy", {31'b0, jtag_busy}, 0);
    chk("rst_overrun", {31'b0, jtag_overrun}, 0);
    chk("rst_ramaddr", {24'b0, ram_addr}, 0);
    chk("rst_wren", {31'b0, ram_wren}, 0);
    reset = 1'b0;

    // JTAG write DEADBEEF to 0x10, then read it back
    act_a = 1; jdo = jdo_addr(1'b0, 8'h10); cyc();
    act_a = 0; act_b = 1; jdo = jdo_data(32'hDEADBEEF); settle();
    chk("t1_busy_pre", {31'b0, jtag_busy}, 0);
    cyc();
    act_b = 0; settle();
    chk("t1_busy_wr", {31'b0, jtag_busy}, 1);
    chk("t1_wr_addr", {24'b0, ram_addr}, 32'h10);
    chk("t1_wr_wren", {31'b0, ram_wren}, 1);
    chk("t1_wr_data", ram_wdata, 32'hDEADBEEF);
    chk("t1_wr_be", {28'b0, ram_byteen}, 32'hF);
    cyc();
    chk("t1_wr_ready", {31'b0, mon_ready}, 1);
    chk("t1_wr_mond", MonDReg, 0);
    chk("t1_addr_inc", {24'b0, dut.w_jtag_addr}, 32'h11);
    chk("t1_wr_busy_done", {31'b0, jtag_busy}, 0);
    act_a = 1; jdo = jdo_addr(1'b1, 8'h10); cyc();
    act_a = 0; settle();
    chk("t1_rd_addr", {24'b0, ram_addr}, 32'h10);
    chk("t1_rd_wren", {31'b0, ram_wren}, 0);
    chk("t1_rd_ready_early", {31'b0, mon_ready}, 0);
    cyc();
    chk("t1_rd_ready", {31'b0, mon_ready}, 1);
    chk("t1_rd_mond", MonDReg, 32'hDEADBEEF);
    chk("t1_rd_busy", {31'b0, jtag_busy}, 1);
    chk("t1_rd_addr_after", {24'b0, dut.w_jtag_addr}, 32'h11);
    cyc();
    chk("t1_ready_once", {31'b0, mon_ready}, 0);
    chk("t1_mond_hold", MonDReg, 32'hDEADBEEF);
    chk("t1_busy_idle", {31'b0, jtag_busy}, 0);

    // CPU write 0x20, then contention against JTAG reads plus an overrun
    cpu_write = 1; cpu_address = 8'h20; cpu_writedata = 32'hCAFEF00D; cpu_byteenable = 4'hF;
    settle();
    chk("t2_cpuwr_wait", {31'b0, cpu_waitrequest}, 0);
    chk("t2_cpuwr_wren", {31'b0, ram_wren}, 1);
    cyc();
    cpu_write = 0; cpu_read = 1; act_a = 1; jdo = jdo_addr(1'b1, 8'h10); settle();
    chk("t2_h_wait", {31'b0, cpu_waitrequest}, 0);
    cyc();
    act_a = 0; settle();
    chk("t2_i_wait", {31'b0, cpu_waitrequest}, 0);
    chk("t2_i_rvalid", {31'b0, cpu_readdatavalid}, 1);
    chk("t2_i_rdata", cpu_readdata, 32'hCAFEF00D);
    cyc();
    chk("t2_j_wait", {31'b0, cpu_waitrequest}, 1);
    chk("t2_j_ramaddr", {24'b0, ram_addr}, 32'h10);
    chk("t2_j_rvalid", {31'b0, cpu_readdatavalid}, 1);
    cyc();
    noact_a = 1; settle();
    chk("t2_k_wait", {31'b0, cpu_waitrequest}, 0);
    chk("t2_k_rvalid", {31'b0, cpu_readdatavalid}, 0);
    chk("t2_k_ready", {31'b0, mon_ready}, 1);
    chk("t2_k_mond", MonDReg, 32'hDEADBEEF);
    cyc();
    chk("t2_l_wait", {31'b0, cpu_waitrequest}, 0);
    chk("t2_l_rvalid", {31'b0, cpu_readdatavalid}, 1);
    chk("t2_l_rdata", cpu_readdata, 32'hCAFEF00D);
    chk("t2_l_overrun_pre", {31'b0, jtag_overrun}, 0);
    cyc();
    noact_a = 0; settle();
    chk("t2_m_wait", {31'b0, cpu_waitrequest}, 1);
    chk("t2_m_overrun", {31'b0, jtag_overrun}, 1);
    chk("t2_m_rvalid", {31'b0, cpu_readdatavalid}, 1);
    cyc();
    chk("t2_n_wait", {31'b0, cpu_waitrequest}, 0);
    chk("t2_n_ready", {31'b0, mon_ready}, 1);
    chk("t2_n_rvalid", {31'b0, cpu_readdatavalid}, 0);
    cyc();
    cpu_read = 0; settle();
    chk("t2_o_ready", {31'b0, mon_ready}, 0);
    chk("t2_o_rvalid", {31'b0, cpu_readdatavalid}, 1);
    chk("t2_o_busy", {31'b0, jtag_busy}, 0);
    cyc();
    chk("t2_p_ready", {31'b0, mon_ready}, 0);

    // reset in the grant cycle of a CPU read suppresses its valid
    cpu_read = 1; cpu_address = 8'h20; settle();
    chk("t3_grant", {31'b0, cpu_waitrequest}, 0);
    reset = 1; cpu_read = 0; cyc();
    chk("t3_rvalid", {31'b0, cpu_readdatavalid}, 0);
    chk("t3_overrun", {31'b0, jtag_overrun}, 0);
    chk("t3_mond", MonDReg, 0);
    chk("t3_ramaddr", {24'b0, ram_addr}, 0);
    chk("t3_rdata", cpu_readdata, 0);
    reset = 0; cyc();
    chk("t3_rvalid_late", {31'b0, cpu_readdatavalid}, 0);

    // address wrap, with a strobe accepted in the grant cycle
    act_a = 1; jdo = jdo_addr(1'b0, 8'hFF); cyc();
    act_a = 0; act_b = 1; jdo = jdo_data(32'h1); cyc();
    act_b = 0; noact_a = 1; settle();
    chk("t4_wr_addr", {24'b0, ram_addr}, 32'hFF);
    chk("t4_wr_wren", {31'b0, ram_wren}, 1);
    chk("t4_wr_data", ram_wdata, 32'h1);
    cyc();
    noact_a = 0; settle();
    chk("t4_no_overrun", {31'b0, jtag_overrun}, 0);
    chk("t4_wrapped", {24'b0, dut.w_jtag_addr}, 0);
    chk("t4_rd0_addr", {24'b0, ram_addr}, 0);
    chk("t4_wr_ready", {31'b0, mon_ready}, 1);
    cyc();
    act_a = 1; jdo = jdo_addr(1'b1, 8'hFF); settle();
    chk("t4_rd0_ready", {31'b0, mon_ready}, 1);
    cyc();
    act_a = 0; settle();
    chk("t4_rdff_addr", {24'b0, ram_addr}, 32'hFF);
    cyc();
    chk("t4_rdff_mond", MonDReg, 32'h1);
    chk("t4_rdff_ready", {31'b0, mon_ready}, 1);
    cyc();

    // simultaneous strobes: act_a wins, others dropped
    act_a = 1; act_b = 1; noact_a = 1; jdo = jdo_addr(1'b0, 8'h40); cyc();
    act_a = 0; act_b = 0; noact_a = 0; settle();
    chk("t5_overrun", {31'b0, jtag_overrun}, 1);
    chk("t5_busy", {31'b0, jtag_busy}, 0);
    chk("t5_addr", {24'b0, dut.w_jtag_addr}, 32'h40);

    // CPU write into the lower half, then JTAG write there
    cpu_write = 1; cpu_address = 8'h05; cpu_writedata = 32'h55; cpu_byteenable = 4'h6; settle();
    chk("t6_cpu_wait", {31'b0, cpu_waitrequest}, 0);
    chk("t6_cpu_be", {28'b0, ram_byteen}, 32'h6);
`ifdef OCIMEM_ROM_PROTECT_EN
    chk("t6_cpu_wren", {31'b0, ram_wren}, 0);
`else
    chk("t6_cpu_wren", {31'b0, ram_wren}, 1);
`endif
    cyc();
    cpu_write = 0; act_a = 1; jdo = jdo_addr(1'b0, 8'h05); cyc();
    act_a = 0; act_b = 1; jdo = jdo_data(32'h77); cyc();
    act_b = 0; settle();
    chk("t6_jtag_wren", {31'b0, ram_wren}, 1);
    chk("t6_jtag_addr", {24'b0, ram_addr}, 32'h05);
    chk("t6_jtag_data", ram_wdata, 32'h77);
    cyc();
    cpu_read = 1; cpu_address = 8'h05; settle();
    chk("t6_rd_wait", {31'b0, cpu_waitrequest}, 0);
    cyc();
    cpu_read = 0; settle();
    chk("t6_rd_valid", {31'b0, cpu_readdatavalid}, 1);
    chk("t6_rd_data", cpu_readdata, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
